dijkstra_axil_regs: RTL and testbench
=====================================

DIJKSTRA_AXIL_REGS -- requirements
Module: dijkstra_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width (8 word slots).
REQ-003 Port ACLK, input, 1, the single clock; all logic rising-edge.
REQ-004 Port ARESET, input, 1, asynchronous active-high reset.
REQ-005 Ports S_AXI_AWADDR in [ADDR-1:0], S_AXI_AWPROT in 3, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address channel (AWPROT ignored).
REQ-006 Ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data channel.
REQ-007 Ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
REQ-008 Ports S_AXI_ARADDR in [ADDR-1:0], S_AXI_ARPROT in 3, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address channel (ARPROT ignored).
REQ-009 Ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.
REQ-010 Port start_o, output, 1, one-cycle start pulse to the Dijkstra core.
REQ-011 Port busy_i, input, 1, core busy level; done_i, input, 1, one-cycle core completion pulse.
REQ-012 Port irq_o, output, 1, level interrupt.
REQ-013 Ports ctrl_o, src_o, dst_o, cfg_o, output, 32 each: current values of REG0..REG3.

Function
REQ-014 Register map (word offset): 0x00 REG0 CTRL, 0x04 REG1 SRC, 0x08 REG2 DST, 0x0C REG3 CFG, all RW full 32 bits; 0x10 STATUS RO = {30'b0, done_sticky, busy_i}; 0x14-0x1C unmapped.
REQ-015 Address decode SHALL use addr[4:2]; addr[1:0] ignored.
REQ-016 Write: AW and W accepted independently in any order; each READY is asserted for one cycle when its VALID is high and no address/data of that kind is already held and BVALID is low.
REQ-017 Register update SHALL occur in the cycle after both address and data are held; only byte lanes with WSTRB[n]=1 update.
REQ-018 BVALID SHALL assert in the same cycle as the register update and hold, with BRESP stable, until BREADY; no new AW/W accepted while BVALID is high.
REQ-019 BRESP SHALL be 2'b00 for 0x00-0x0C, 2'b10 (SLVERR) for STATUS and unmapped offsets; those writes change no state.
REQ-020 start_o SHALL pulse high for exactly one cycle, in the cycle after the update, for every accepted REG0 write with WSTRB[0]=1 and WDATA[0]=1; REG0 bit0 retains the written value.
REQ-021 Read: ARREADY asserted for one cycle when ARVALID high and RVALID low; RVALID asserts the next cycle with RDATA/RRESP registered and holds stable until RREADY.
REQ-022 RRESP 2'b00 for 0x00-0x10; 2'b10 with RDATA=0 for unmapped.
REQ-023 done_sticky SHALL set on done_i=1 and clear when a STATUS read is accepted (ARREADY&ARVALID); simultaneous set and clear: set wins; RDATA captures pre-clear value.
REQ-024 irq_o = done_sticky AND REG0[1], registered-free combinational from flops.
REQ-025 Read and write paths SHALL operate concurrently; a read of a register in the same cycle as its update returns the old value.
REQ-026 Maximum throughput: one write per 2 cycles with BREADY held high; one read per 2 cycles with RREADY held high.

Reset
REQ-027 While ARESET=1: REG0-REG3=0, done_sticky=0, all READY/VALID outputs 0, BRESP=RRESP=0, RDATA=0, start_o=0, irq_o=0; any in-flight transaction is discarded, no response issued after reset release.
REQ-028 ARESET asserts asynchronously; deassertion takes effect at the next ACLK edge; first transaction accepted no earlier than the cycle after release.

Verification
REQ-029 Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, then read back -> RDATA 0x1..0x4, all RESP OKAY, start_o exactly one pulse (first write).
REQ-030 W presented 3 cycles before AW to 0x04 with WDATA 0xAABBCCDD, WSTRB 4'b0101, REG1 previously 0 -> REG1=0x00BB00DD; BVALID held 5 cycles with BREADY low then released.
REQ-031 Write REG0=0x2, pulse done_i -> irq_o=1, STATUS read returns 0x2 (busy_i=0), next STATUS read returns 0x0, irq_o=0.
REQ-032 done_i pulses in same cycle STATUS read accepted -> that read returns bit1=1 and done_sticky stays 1.
REQ-033 Write 0x18 and 0x10, read 0x1C -> BRESP 2'b10 twice, RRESP 2'b10 RDATA 0, no register changes.
REQ-034 Assert ARESET while BVALID pending and RVALID pending -> both drop immediately, registers 0, no response after release.

Source files
------------

// File: rtl/dijkstra_axil_regs.sv
// dijkstra_axil_regs: AXI4-Lite control/status registers and start/irq glue for the Dijkstra core.
// Latency: a write commits on the edge where both AW and W are in hand (BVALID next cycle); read data one cycle after AR.
// Backpressure: AW/W stall while a B response is pending, AR stalls while R is pending; B and R hold until BREADY/RREADY.
module dijkstra_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            start_o,
  input  logic                            busy_i,
  input  logic                            done_i,
  output logic                            irq_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   src_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   dst_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_o
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  // Register file and channel state
  logic [DW-1:0] r_reg [0:3];
  logic          r_en;
  logic          r_aw_held, r_w_held;
  logic [2:0]    r_aw_idx;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;
  logic          r_bvalid;
  logic [1:0]    r_bresp;
  logic          r_start_arm, r_start;
  logic          r_rvalid;
  logic [1:0]    r_rresp;
  logic [DW-1:0] r_rdata;
  logic          r_done_sticky;

  logic          w_aw_hs, w_w_hs, w_ar_hs, w_wr_fire;
  logic [2:0]    w_wr_idx, w_rd_idx;
  logic [DW-1:0] w_wr_data, w_wr_merged;
  logic [SW-1:0] w_wr_strb;
  logic          w_unused;

  // Protection bits and byte offset are don't-care for this block
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // r_en keeps every READY low until the first edge after reset release
  assign S_AXI_AWREADY = r_en & S_AXI_AWVALID & ~r_aw_held & ~r_bvalid;
  assign S_AXI_WREADY  = r_en & S_AXI_WVALID  & ~r_w_held  & ~r_bvalid;
  assign S_AXI_ARREADY = r_en & S_AXI_ARVALID & ~r_rvalid;

  assign w_aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_w_hs    = S_AXI_WVALID  & S_AXI_WREADY;
  assign w_ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
  assign w_wr_fire = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

  // A held beat takes precedence over the live bus, since the live one cannot be accepted then
  assign w_wr_idx  = r_aw_held ? r_aw_idx : S_AXI_AWADDR[4:2];
  assign w_wr_data = r_w_held  ? r_wdata  : S_AXI_WDATA;
  assign w_wr_strb = r_w_held  ? r_wstrb  : S_AXI_WSTRB;
  assign w_rd_idx  = S_AXI_ARADDR[4:2];

  // Byte-lane merge of the write data into the currently addressed register
  always_comb begin
    w_wr_merged = r_reg[w_wr_idx[1:0]];
    for (int b = 0; b < SW; b++) begin
      if (w_wr_strb[b]) w_wr_merged[8*b +: 8] = w_wr_data[8*b +: 8];
    end
  end

  // Write path: capture AW/W independently, commit and raise BVALID once both are present
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_en        <= 1'b0;
      r_aw_held   <= 1'b0;
      r_w_held    <= 1'b0;
      r_aw_idx    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_bvalid    <= 1'b0;
      r_bresp     <= 2'b00;
      r_start_arm <= 1'b0;
      r_start     <= 1'b0;
      for (int i = 0; i < 4; i++) r_reg[i] <= '0;
    end else begin
      r_en        <= 1'b1;
      r_start     <= r_start_arm;
      r_start_arm <= 1'b0;
      if (w_wr_fire) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        if (!w_wr_idx[2]) begin
          r_reg[w_wr_idx[1:0]] <= w_wr_merged;
          r_bresp              <= 2'b00;
          r_start_arm          <= (w_wr_idx == 3'd0) & w_wr_strb[0] & w_wr_data[0];
        end else begin
          r_bresp <= 2'b10;
        end
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_idx  <= S_AXI_AWADDR[4:2];
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= S_AXI_WDATA;
          r_wstrb  <= S_AXI_WSTRB;
        end
        if (r_bvalid && S_AXI_BREADY) r_bvalid <= 1'b0;
      end
    end
  end

  // Read path and done_sticky: STATUS read reports sticky|done_i, clears sticky unless done_i is set again
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rvalid      <= 1'b0;
      r_rresp       <= 2'b00;
      r_rdata       <= '0;
      r_done_sticky <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rresp  <= 2'b00;
        case (w_rd_idx)
          3'd0, 3'd1, 3'd2, 3'd3: r_rdata <= r_reg[w_rd_idx[1:0]];
          3'd4:    r_rdata <= {{(DW-2){1'b0}}, r_done_sticky | done_i, busy_i};
          default: begin
            r_rdata <= '0;
            r_rresp <= 2'b10;
          end
        endcase
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
      if (done_i) r_done_sticky <= 1'b1;
      else if (w_ar_hs && w_rd_idx == 3'd4) r_done_sticky <= 1'b0;
    end
  end

  assign S_AXI_BVALID = r_bvalid;
  assign S_AXI_BRESP  = r_bresp;
  assign S_AXI_RVALID = r_rvalid;
  assign S_AXI_RRESP  = r_rresp;
  assign S_AXI_RDATA  = r_rdata;
  assign start_o      = r_start;
  assign irq_o        = r_done_sticky & r_reg[0][1];
  assign ctrl_o       = r_reg[0];
  assign src_o        = r_reg[1];
  assign dst_o        = r_reg[2];
  assign cfg_o        = r_reg[3];

endmodule

// File: tb/tb_dijkstra_axil_regs.sv
// Bench for dijkstra_axil_regs: directed register-map scenarios followed by randomized
// AXI4-Lite traffic, all compared against a word-level model of the register map.
module tb_dijkstra_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [4:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [4:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic        start_o;
  logic        busy_i = 1'b0;
  logic        done_i = 1'b0;
  logic        irq_o;
  logic [31:0] ctrl_o, src_o, dst_o, cfg_o;

  always #5 ACLK = ~ACLK;

  dijkstra_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .start_o(start_o), .busy_i(busy_i), .done_i(done_i), .irq_o(irq_o),
    .ctrl_o(ctrl_o), .src_o(src_o), .dst_o(dst_o), .cfg_o(cfg_o)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;
  int start_seen = 0;

  // Reference model: four RW words, done_sticky, and the number of start pulses owed
  logic [31:0] m_reg [4];
  logic        m_sticky;
  int          m_starts;

  // Each cycle start_o is high counts as one pulse, so a stretched pulse is caught
  always @(negedge ACLK) if (start_o === 1'b1) start_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
    m_sticky = 1'b0;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    logic [31:0] mask;
    int          word;
    word = int'(a) / 4;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (word < 4) begin
      m_reg[word] = (m_reg[word] & ~mask) | (d & mask);
      resp = 2'b00;
      if (word == 0 && s[0] && d[0]) m_starts++;
    end else begin
      resp = 2'b10;
    end
  endtask

  task automatic model_read(input logic [4:0] a, input logic done_same,
                            output logic [31:0] d, output logic [1:0] resp);
    int word;
    word = int'(a) / 4;
    resp = 2'b00;
    if (word < 4) d = m_reg[word];
    else if (word == 4) d = {30'b0, m_sticky | done_same, busy_i};
    else begin
      d = 32'h0;
      resp = 2'b10;
    end
    if (word == 4) m_sticky = 1'b0;
    if (done_same) m_sticky = 1'b1;
  endtask

  task automatic check_ports(input string tag);
    check({tag, "_ctrl"}, ctrl_o, m_reg[0]);
    check({tag, "_src"}, src_o, m_reg[1]);
    check({tag, "_dst"}, dst_o, m_reg[2]);
    check({tag, "_cfg"}, cfg_o, m_reg[3]);
    check({tag, "_irq"}, 32'(irq_o), 32'(m_sticky & m_reg[0][1]));
  endtask

  task automatic drive_aw(input logic [4:0] a, input int dly);
    repeat (dly) @(negedge ACLK);
    S_AXI_AWADDR = a;
    S_AXI_AWVALID = 1'b1;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (S_AXI_AWREADY) begin
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        return;
      end
      @(negedge ACLK);
    end
    S_AXI_AWVALID = 1'b0;
    check("aw_handshake_timeout", 32'(S_AXI_AWREADY), 32'd1);
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    repeat (dly) @(negedge ACLK);
    S_AXI_WDATA = d;
    S_AXI_WSTRB = s;
    S_AXI_WVALID = 1'b1;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (S_AXI_WREADY) begin
        @(negedge ACLK);
        S_AXI_WVALID = 1'b0;
        return;
      end
      @(negedge ACLK);
    end
    S_AXI_WVALID = 1'b0;
    check("w_handshake_timeout", 32'(S_AXI_WREADY), 32'd1);
  endtask

  task automatic finish_b(input int b_dly, output logic [1:0] resp);
    int t;
    t = 0;
    resp = 2'bxx;
    while (!S_AXI_BVALID && t < 40) begin
      @(negedge ACLK);
      t++;
    end
    if (!S_AXI_BVALID) begin
      check("bvalid_timeout", 32'(S_AXI_BVALID), 32'd1);
      return;
    end
    resp = S_AXI_BRESP;
    for (int i = 1; i < b_dly; i++) begin
      @(negedge ACLK);
      check("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
      check("bresp_stable", 32'(S_AXI_BRESP), 32'(resp));
    end
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    check("bvalid_clear", 32'(S_AXI_BVALID), 32'd0);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp);
    fork
      drive_aw(a, aw_dly);
      drive_w(d, s, w_dly);
    join
    finish_b(b_dly, resp);
  endtask

  task automatic drive_ar(input logic [4:0] a, input logic pulse_done);
    S_AXI_ARADDR = a;
    S_AXI_ARVALID = 1'b1;
    done_i = pulse_done;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (S_AXI_ARREADY) begin
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        done_i = 1'b0;
        return;
      end
      @(negedge ACLK);
    end
    S_AXI_ARVALID = 1'b0;
    done_i = 1'b0;
    check("ar_handshake_timeout", 32'(S_AXI_ARREADY), 32'd1);
  endtask

  task automatic axi_read(input logic [4:0] a, input logic pulse_done, input int r_dly,
                          output logic [31:0] d, output logic [1:0] resp);
    int t;
    drive_ar(a, pulse_done);
    t = 0;
    d = 'x;
    resp = 2'bxx;
    while (!S_AXI_RVALID && t < 40) begin
      @(negedge ACLK);
      t++;
    end
    if (!S_AXI_RVALID) begin
      check("rvalid_timeout", 32'(S_AXI_RVALID), 32'd1);
      return;
    end
    d = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    for (int i = 1; i < r_dly; i++) begin
      @(negedge ACLK);
      check("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
      check("rdata_stable", S_AXI_RDATA, d);
    end
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    check("rvalid_clear", 32'(S_AXI_RVALID), 32'd0);
  endtask

  // Hard stop in case a wait escapes its bound
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp, eresp;
    logic [31:0] rd, erd, wd;
    logic [4:0]  a;
    logic [3:0]  s;
    logic        pd;
    int          kind;

    model_reset();
    m_starts = 0;

    // Reset state, with requests pending on every channel
    repeat (3) @(negedge ACLK);
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID = 1'b1;
    S_AXI_ARVALID = 1'b1;
    #1;
    check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("rst_wready", 32'(S_AXI_WREADY), 32'd0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("rst_bresp", 32'(S_AXI_BRESP), 32'd0);
    check("rst_rresp", 32'(S_AXI_RRESP), 32'd0);
    check("rst_rdata", S_AXI_RDATA, 32'd0);
    check("rst_start", 32'(start_o), 32'd0);
    check_ports("rst");
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID = 1'b0;
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);

    // Basic write of REG0..REG3 then readback
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, resp);
      model_write(5'(i * 4), 32'(i + 1), 4'hF, eresp);
      check("basic_bresp", 32'(resp), 32'(eresp));
    end
    repeat (3) @(negedge ACLK);
    check("basic_start_count", 32'(start_seen), 32'(m_starts));
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), 1'b0, 0, rd, resp);
      model_read(5'(i * 4), 1'b0, erd, eresp);
      check("basic_rdata", rd, erd);
      check("basic_rdata_const", rd, 32'(i + 1));
      check("basic_rresp", 32'(resp), 32'(eresp));
    end
    check_ports("basic");

    // W leads AW by three cycles, partial strobes, B held off for five cycles
    axi_write(5'h04, 32'h0, 4'hF, 0, 0, 0, resp);
    model_write(5'h04, 32'h0, 4'hF, eresp);
    axi_write(5'h04, 32'hAABBCCDD, 4'b0101, 3, 0, 5, resp);
    model_write(5'h04, 32'hAABBCCDD, 4'b0101, eresp);
    check("strb_bresp", 32'(resp), 32'(eresp));
    check("strb_src_const", src_o, 32'h00BB00DD);
    check_ports("strb");

    // done_i raises irq when CTRL bit1 is set; STATUS read clears it
    busy_i = 1'b0;
    axi_write(5'h00, 32'h2, 4'hF, 0, 0, 0, resp);
    model_write(5'h00, 32'h2, 4'hF, eresp);
    done_i = 1'b1;
    @(negedge ACLK);
    done_i = 1'b0;
    m_sticky = 1'b1;
    check("irq_set", 32'(irq_o), 32'd1);
    axi_read(5'h10, 1'b0, 0, rd, resp);
    model_read(5'h10, 1'b0, erd, eresp);
    check("status_sticky", rd, 32'h2);
    check("status_sticky_model", rd, erd);
    axi_read(5'h10, 1'b0, 0, rd, resp);
    model_read(5'h10, 1'b0, erd, eresp);
    check("status_cleared", rd, 32'h0);
    check("irq_clear", 32'(irq_o), 32'd0);

    // done_i coinciding with the STATUS read: set wins, busy reported in bit0
    busy_i = 1'b1;
    axi_read(5'h10, 1'b1, 0, rd, resp);
    model_read(5'h10, 1'b1, erd, eresp);
    check("status_race_rdata", rd, erd);
    check("status_race_bit1", 32'(rd[1]), 32'd1);
    check("status_race_irq", 32'(irq_o), 32'd1);
    axi_read(5'h12, 1'b0, 0, rd, resp);
    model_read(5'h12, 1'b0, erd, eresp);
    check("status_after_race", rd, erd);
    busy_i = 1'b0;

    // STATUS and unmapped offsets answer SLVERR and change nothing
    axi_write(5'h18, 32'hDEADBEEF, 4'hF, 0, 1, 0, resp);
    model_write(5'h18, 32'hDEADBEEF, 4'hF, eresp);
    check("unmapped_bresp", 32'(resp), 32'd2);
    axi_write(5'h10, 32'hFFFFFFFF, 4'hF, 1, 0, 0, resp);
    model_write(5'h10, 32'hFFFFFFFF, 4'hF, eresp);
    check("status_wr_bresp", 32'(resp), 32'd2);
    axi_read(5'h1C, 1'b0, 2, rd, resp);
    model_read(5'h1C, 1'b0, erd, eresp);
    check("unmapped_rresp", 32'(resp), 32'd2);
    check("unmapped_rdata", rd, 32'h0);
    check_ports("unmapped");

    // Randomized traffic against the model
    for (int it = 0; it < 120; it++) begin
      kind = int'($urandom_range(0, 9));
      a = 5'($urandom_range(0, 31));
      if (kind == 0) begin
        done_i = 1'b1;
        @(negedge ACLK);
        done_i = 1'b0;
        m_sticky = 1'b1;
      end else if (kind <= 4) begin
        busy_i = 1'($urandom_range(0, 1));
        pd = ($urandom_range(0, 3) == 0);
        axi_read(a, pd, int'($urandom_range(0, 3)), rd, resp);
        model_read(a, pd, erd, eresp);
        check("rand_rdata", rd, erd);
        check("rand_rresp", 32'(resp), 32'(eresp));
      end else begin
        wd = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, wd, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), resp);
        model_write(a, wd, s, eresp);
        check("rand_bresp", 32'(resp), 32'(eresp));
      end
      check_ports("rand");
    end
    repeat (3) @(negedge ACLK);
    check("rand_start_count", 32'(start_seen), 32'(m_starts));

    // Reset with both a B and an R response outstanding
    axi_write(5'h08, 32'h0000_0002, 4'hF, 0, 0, 0, resp);
    model_write(5'h08, 32'h0000_0002, 4'hF, eresp);
    fork
      drive_aw(5'h0C, 0);
      drive_w(32'h12345678, 4'hF, 0);
    join
    drive_ar(5'h08, 1'b0);
    @(negedge ACLK);
    check("pre_rst_bvalid", 32'(S_AXI_BVALID), 32'd1);
    check("pre_rst_rvalid", 32'(S_AXI_RVALID), 32'd1);
    ARESET = 1'b1;
    #1;
    check("mid_rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("mid_rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    model_reset();
    check_ports("mid_rst");
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    repeat (5) @(negedge ACLK);
    check("post_rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("post_rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    axi_read(5'h0C, 1'b0, 0, rd, resp);
    model_read(5'h0C, 1'b0, erd, eresp);
    check("post_rst_rdata", rd, erd);
    check_ports("post_rst");
    check("final_start_count", 32'(start_seen), 32'(m_starts));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
